regfile_reader: RTL and testbench
=================================

# regfile_reader

Sequential readout engine for the 32×32 register file: on a start pulse it walks an address range, issues dual-port reads (two registers per read cycle on the AR_1/AR_2 ports), and streams the returned words in ascending address order over a valid/ready interface. It sits between the register file's read side and any debug, scan-out or context-save consumer. It is the read-side counterpart to the stimulus path that loads the file through WD3/AW/WR.

## Interface
- NREGS, 32, number of registers in the file
- AW_W, 5, address width
- DW, 32, data width
- READ_LAT, 1, register-file read latency in cycles from rf_rd/rf_ar* to rf_rd1/rf_rd2; legal values 0 or 1
- FIFO_DEPTH, 4, output buffer depth in words; power of two, ≥2

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; sampled only when busy=0
- first_addr  in  AW_W  first register to read, captured on start
- last_addr  in  AW_W  last register to read inclusive, captured on start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of dump
- rf_en  out  1  register-file enable, high while busy
- rf_rd  out  1  read strobe; high in issue cycles only
- rf_ar1  out  AW_W  even-slot read address
- rf_ar2  out  AW_W  odd-slot read address (rf_ar1+1)
- rf_rd1  in  DW  data for rf_ar1
- rf_rd2  in  DW  data for rf_ar2
- m_valid  out  1  stream word valid
- m_ready  in  1  consumer accepts word
- m_data  out  DW  register contents
- m_addr  out  AW_W  register address of m_data
- m_last  out  1  high on the beat carrying last_addr

## Operation
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: start=1 → capture the range and set next_addr=first_addr. If first_addr>last_addr → FINISH (empty dump, no beats). Otherwise → ISSUE.
- ISSUE: a read is issued when the credit check passes. Credit: free = FIFO_DEPTH − fifo_count − inflight_words.
  - Issue requires free≥2, or free≥1 when remaining=1.
  - On issue: rf_rd=1, rf_ar1=next_addr, rf_ar2=next_addr+1. Returned words are pushed in order rd1 then rd2.
  - When next_addr=last_addr, only rd1 is pushed; rf_ar2 still equals next_addr+1, and when next_addr=NREGS−1 the value wraps to 0 and is ignored. No other wrap occurs.
  - next_addr advances by 2 per issue. After the final issue → DRAIN.
- DRAIN: wait until inflight=0 and the FIFO is empty, with the last beat accepted → FINISH.
- FINISH: done=1 for one cycle, busy=0 → IDLE.
- Stream rules:
  - Once m_valid=1, it stays high and m_data/m_addr/m_last stay stable until m_valid&m_ready.
  - m_last=1 only with m_addr=last_addr.
- start while busy=1 is ignored.
- Reset, including mid-dump: FIFO and in-flight tracking are flushed, FSM → IDLE, any pending read return is discarded.
- Reset values: busy, done, rf_en, rf_rd, m_valid, m_last = 0; rf_ar1, rf_ar2, m_addr = 0; m_data = 0.

## Timing
- Cycle 0: start sampled. Cycle 1: busy=1, first issue (rf_rd=1, rf_ar1=first_addr).
- Data is captured into the FIFO at the end of cycle 1+READ_LAT. m_valid rises in cycle 2+READ_LAT, i.e. cycle 3 at the default.
- With m_ready held high, the output sustains 1 word/cycle after fill. Issue pauses whenever the credit check fails.
- Empty range: done in cycle 1, busy never rises, no rf_rd.
- done occurs exactly one cycle after the handshake of the m_last beat. busy falls in that same done cycle.
- A simultaneous FIFO push and pop in one cycle is legal, and count is unchanged.

## Structure
- Package regfile_pkg holds NREGS, AW_W and DW, shared with the register file and its benches, plus the FSM state enum.
- One sub-module, regfile_reader_fifo: a synchronous FIFO carrying {addr, last, data} at FIFO_DEPTH, with count output, first-word-fall-through, and synchronous reset flush.
- In-flight tracking is a READ_LAT-deep shift register of {valid, pair_or_single, base_addr}.

## Test plan
- File preloaded with reg[i]=i×32'h0101_0101; start, range 0..31, m_ready=1 → 32 beats, addr 0..31 in order, correct data, m_last on addr 31, done once, 16 rf_rd pulses.
- Range 3..5 → 3 beats (addr 3, 4, 5); second issue has rf_ar1=5, and rd2 is dropped; m_last on 5.
- Range 31..31 → 1 beat with data reg[31]; rf_ar2=0 is ignored; done follows.
- Range 10..2 → done in cycle 1, no rf_rd, no m_valid.
- Range 0..31 with m_ready low for 12 cycles from cycle 4 → m_valid held with stable data, at most 4 words buffered, no issue while free<2, full data intact after release.
- rst pulsed mid-dump at beat 7 → all outputs 0 next cycle; a new start on 0..1 yields exactly 2 correct beats; a start asserted while busy produces no extra beats.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file geometry plus the readout engine's state, beat and in-flight types.
package regfile_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned AW_W  = $clog2(NREGS);
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

    // One streamed word as held in the output buffer
    typedef struct packed {
        logic [AW_W-1:0] addr;
        logic            last;
        logic [DW-1:0]   data;
    } beat_t;

    localparam int unsigned BEAT_W = $bits(beat_t);

    // One outstanding dual-port read: pair=1 when both rd1 and rd2 are wanted
    typedef struct packed {
        logic            valid;
        logic            pair;
        logic [AW_W-1:0] base;
    } infl_t;

    function automatic logic [1:0] words(input infl_t e);
        if (!e.valid) begin
            return 2'd0;
        end
        return e.pair ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/regfile_reader_fifo.sv
// First-word-fall-through output buffer taking up to two words per cycle (rd1 then rd2).
module regfile_reader_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push1,
    input  logic                   push2,
    input  logic [BEAT_W-1:0]      din1,
    input  logic [BEAT_W-1:0]      din2,
    input  logic                   pop,
    output logic [BEAT_W-1:0]      dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = PW + 1;

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        push_n;

    // push2 is only ever raised together with push1
    assign push_n = {1'b0, push1} + {1'b0, push2};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push1) begin
                mem_q[wr_ptr_q] <= din1;
            end
            if (push2) begin
                mem_q[wr_ptr_q + PW'(1)] <= din2;
            end
            wr_ptr_q <= wr_ptr_q + PW'(push_n);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop);
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/regfile_reader.sv
// Walks a register-file address range with dual-port reads and streams the words in
// ascending address order over valid/ready, issuing only when the output buffer has room.
module regfile_reader
    import regfile_pkg::*;
#(
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW_W-1:0] first_addr,
    input  logic [AW_W-1:0] last_addr,
    output logic            busy,
    output logic            done,
    output logic            rf_en,
    output logic            rf_rd,
    output logic [AW_W-1:0] rf_ar1,
    output logic [AW_W-1:0] rf_ar2,
    input  logic [DW-1:0]   rf_rd1,
    input  logic [DW-1:0]   rf_rd2,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DW-1:0]   m_data,
    output logic [AW_W-1:0] m_addr,
    output logic            m_last
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 3;
    localparam int unsigned NA_W  = AW_W + 1;

    state_t          state_q;
    logic [NA_W-1:0] next_q;
    logic [AW_W-1:0] last_q;
    logic            iss_pair_q;

    infl_t            iss;
    infl_t            ret;
    logic [OCC_W-1:0] pipe_words;
    logic [OCC_W-1:0] inflight;
    logic [OCC_W-1:0] need;
    logic [CNT_W-1:0] fifo_count;
    logic             pop;
    logic             credit_ok;
    logic             issue_go;
    logic             issue_final;
    logic [NA_W-1:0]  issue_base;
    logic [AW_W-1:0]  last_ref;
    beat_t            din1;
    beat_t            din2;
    beat_t            dout;
    logic             push1;
    logic             push2;

    // The read presented on the register-file port this cycle
    always_comb begin
        iss       = '0;
        iss.valid = rf_rd;
        iss.pair  = iss_pair_q;
        iss.base  = rf_ar1;
    end

    // Return pipeline: a READ_LAT-deep record of reads whose data has not yet arrived
    generate
        if (READ_LAT == 0) begin : g_lat0
            assign ret        = iss;
            assign pipe_words = '0;
        end else begin : g_pipe
            infl_t pipe_q [READ_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < int'(READ_LAT); i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q[0] <= iss;
                    for (int i = 1; i < int'(READ_LAT); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            always_comb begin
                pipe_words = '0;
                for (int i = 0; i < int'(READ_LAT); i++) begin
                    pipe_words = pipe_words + OCC_W'(words(pipe_q[i]));
                end
            end

            assign ret = pipe_q[READ_LAT-1];
        end
    endgenerate

    assign pop      = m_valid & m_ready;
    assign inflight = OCC_W'(words(iss)) + pipe_words;

    // A word popped this cycle frees its slot before the next issue can land
    always_comb begin
        need      = (next_q == {1'b0, last_q}) ? OCC_W'(1) : OCC_W'(2);
        credit_ok = (OCC_W'(fifo_count) + inflight + need)
                    <= (OCC_W'(FIFO_DEPTH) + OCC_W'(pop));
    end

    always_comb begin
        issue_go   = 1'b0;
        issue_base = next_q;
        last_ref   = last_q;
        case (state_q)
            IDLE: begin
                if (start && (first_addr <= last_addr)) begin
                    issue_go   = 1'b1;
                    issue_base = {1'b0, first_addr};
                    last_ref   = last_addr;
                end
            end
            ISSUE:   issue_go = credit_ok;
            default: issue_go = 1'b0;
        endcase
        issue_final = (issue_base + NA_W'(1)) >= {1'b0, last_ref};
    end

    always_comb begin
        push1     = ret.valid;
        push2     = ret.valid & ret.pair;
        din1      = '0;
        din1.addr = ret.base;
        din1.last = (ret.base == last_q);
        din1.data = rf_rd1;
        din2      = '0;
        din2.addr = ret.base + AW_W'(1);
        din2.last = ((ret.base + AW_W'(1)) == last_q);
        din2.data = rf_rd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rf_en      <= 1'b0;
            rf_rd      <= 1'b0;
            rf_ar1     <= '0;
            rf_ar2     <= '0;
            iss_pair_q <= 1'b0;
            next_q     <= '0;
            last_q     <= '0;
        end else begin
            done  <= 1'b0;
            rf_rd <= 1'b0;

            if (issue_go) begin
                rf_rd      <= 1'b1;
                rf_ar1     <= issue_base[AW_W-1:0];
                rf_ar2     <= issue_base[AW_W-1:0] + AW_W'(1);
                iss_pair_q <= (issue_base != {1'b0, last_ref});
                next_q     <= issue_base + NA_W'(2);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        last_q <= last_addr;
                        if (first_addr > last_addr) begin
                            state_q <= FINISH;
                            done    <= 1'b1;
                        end else begin
                            busy    <= 1'b1;
                            rf_en   <= 1'b1;
                            state_q <= issue_final ? DRAIN : ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_go && issue_final) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The m_last beat leaves only after every earlier read has drained
                    if (pop && m_last) begin
                        state_q <= FINISH;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rf_en   <= 1'b0;
                    end
                end
                FINISH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    regfile_reader_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push1(push1),
        .push2(push2),
        .din1 (din1),
        .din2 (din2),
        .pop  (pop),
        .dout (dout),
        .valid(m_valid),
        .count(fifo_count)
    );

    assign m_data = dout.data;
    assign m_addr = dout.addr;
    assign m_last = dout.last;

endmodule

// File: tb/tb_regfile_reader.sv
// Scoreboard bench for regfile_reader: a register-file model answers reads, expected beats
// are queued per dump and a negedge monitor checks stream, issue and timing behaviour.
module tb_regfile_reader;
    import regfile_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW_W-1:0] first_addr;
    logic [AW_W-1:0] last_addr;
    logic            busy;
    logic            done;
    logic            rf_en;
    logic            rf_rd;
    logic [AW_W-1:0] rf_ar1;
    logic [AW_W-1:0] rf_ar2;
    logic [DW-1:0]   rf_rd1;
    logic [DW-1:0]   rf_rd2;
    logic            m_valid;
    logic            m_ready;
    logic [DW-1:0]   m_data;
    logic [AW_W-1:0] m_addr;
    logic            m_last;

    always #5 clk = ~clk;

    regfile_reader #(
        .READ_LAT  (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_addr(first_addr),
        .last_addr (last_addr),
        .busy      (busy),
        .done      (done),
        .rf_en     (rf_en),
        .rf_rd     (rf_rd),
        .rf_ar1    (rf_ar1),
        .rf_ar2    (rf_ar2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_addr    (m_addr),
        .m_last    (m_last)
    );

    typedef struct {
        logic [AW_W-1:0] addr;
        logic            last;
        logic [DW-1:0]   data;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [DW-1:0]   mem [NREGS];
    logic [AW_W-1:0] issue_ar[$];
    logic [AW_W-1:0] cur_last;
    logic            stall_prev;
    logic [AW_W+DW:0] held;

    int checks, errors, cyc;
    int issues, dones, beats, busy_seen, valid_seen, issued_words, accepted_words;
    int start_cyc, first_rd_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
    int ready_mode;
    int mon_w;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file with one cycle of read latency; junk on the bus when not reading
    always @(posedge clk) begin
        rf_rd1 <= rf_rd ? mem[rf_ar1] : $urandom;
        rf_rd2 <= rf_rd ? mem[rf_ar2] : $urandom;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Consumer backpressure patterns
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       m_ready = ($urandom_range(3) != 0);
                2:       m_ready = !((cyc >= start_cyc + 4) && (cyc < start_cyc + 16));
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Monitor: issue rules, buffer bound, stream stability and scoreboard
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (rf_rd) begin
                issues++;
                issue_ar.push_back(rf_ar1);
                if (issues == 1) first_rd_cyc = cyc;
                chk("rf_ar2_is_ar1_plus_1", rf_ar2, AW_W'(rf_ar1 + AW_W'(1)));
                mon_w = (cur_last > rf_ar1) ? 2 : 1;
                issued_words += mon_w;
                checks++;
                if (issued_words - accepted_words > int'(DEPTH)) begin
                    errors++;
                    $display("FAIL credit: outstanding words %0d exceed buffer %0d (cycle %0d)",
                             issued_words - accepted_words, DEPTH, cyc);
                end
            end
            if (m_valid) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (busy) busy_seen++;
            if (stall_prev) begin
                chk("hold_under_stall", {m_valid, m_addr, m_last, m_data}, {1'b1, held});
            end
            if (m_valid && m_ready) begin
                accepted_words++;
                beats++;
                if (m_last) last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: unexpected addr %0d data %0h, nothing expected",
                             m_addr, m_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {m_addr, m_last, m_data}, {mon_e.addr, mon_e.last, mon_e.data});
                end
            end
            stall_prev = m_valid && !m_ready;
            held       = {m_addr, m_last, m_data};
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("busy_low_at_done", busy, 0);
            end
        end
    end

    task automatic do_start(input int f, input int l);
        @(posedge clk);
        #1;
        issues = 0; dones = 0; beats = 0; busy_seen = 0; valid_seen = 0;
        issued_words = 0; accepted_words = 0;
        first_rd_cyc = -1; first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        issue_ar.delete();
        start_cyc  = cyc;
        cur_last   = AW_W'(l);
        first_addr = AW_W'(f);
        last_addr  = AW_W'(l);
        start      = 1'b1;
        for (int a = f; a <= l; a++) begin
            exp_q.push_back('{addr: AW_W'(a), last: (a == l), data: mem[a]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_dump(input int f, input int l, input string tag);
        int n;
        n = 0;
        while (dones == 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        if (dones == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", tag, n);
        end
        repeat (3) @(posedge clk);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_rd_pulses"}, issues, (f <= l) ? ((l - f) / 2 + 1) : 0);
        chk({tag, "_beats"}, beats, (f <= l) ? (l - f + 1) : 0);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        if (f <= l) begin
            chk({tag, "_done_after_last"}, done_cyc - last_hs_cyc, 1);
        end else begin
            chk({tag, "_empty_done_cycle"}, done_cyc - start_cyc, 1);
            chk({tag, "_empty_busy"}, busy_seen, 0);
            chk({tag, "_empty_valid"}, valid_seen, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, f, l, tmp;
        rst        = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        ready_mode = 0;
        cur_last   = '0;
        for (int i = 0; i < int'(NREGS); i++) mem[i] = DW'(i) * 32'h0101_0101;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs",
            {busy, done, rf_en, rf_rd, m_valid, m_last, rf_ar1, rf_ar2, m_addr, m_data}, '0);

        // Full file, consumer always ready
        do_start(0, 31);
        finish_dump(0, 31, "full");
        chk("full_first_issue_cycle", first_rd_cyc - start_cyc, 1);
        chk("full_first_ar1", (issue_ar.size() > 0) ? issue_ar[0] : AW_W'(31), 0);
        chk("full_first_valid_cycle", first_valid_cyc - start_cyc, 3);

        // Odd-length range: last read drops rd2
        do_start(3, 5);
        finish_dump(3, 5, "r3_5");
        chk("r3_5_second_ar1", (issue_ar.size() > 1) ? issue_ar[1] : AW_W'(0), 5);

        // Top register alone: rf_ar2 wraps to 0 and is ignored
        do_start(31, 31);
        finish_dump(31, 31, "r31");

        // Empty range
        do_start(10, 2);
        finish_dump(10, 2, "empty");

        // Consumer stalls for 12 cycles from cycle 4
        ready_mode = 2;
        do_start(0, 31);
        finish_dump(0, 31, "stall");
        ready_mode = 0;

        // Reset mid-dump at beat 7, then a short dump with a start while busy
        do_start(0, 31);
        n = 0;
        while (beats < 7 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (beats < 7) begin
            checks++;
            errors++;
            $display("FAIL midreset_wait: beats %0d required 7", beats);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midreset_outputs",
            {busy, done, rf_en, rf_rd, m_valid, m_last, rf_ar1, rf_ar2, m_addr, m_data}, '0);
        exp_q.delete();
        do_start(0, 1);
        first_addr = AW_W'(5);
        last_addr  = AW_W'(9);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_dump(0, 1, "after_reset");

        // Random ranges, random data and random backpressure
        ready_mode = 1;
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < int'(NREGS); i++) mem[i] = $urandom;
            f = int'($urandom_range(31));
            l = int'($urandom_range(31));
            if (f > l && (t % 4) != 0) begin
                tmp = f;
                f   = l;
                l   = tmp;
            end
            do_start(f, l);
            finish_dump(f, l, "rand");
        end
        ready_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
